// File: rtl/pico_prog_loader.sv
// Byte-stream program loader for PICO_MIPS: packs MSB-first 24-bit words into imem and holds the core in reset until a load completes.
// Optional trailing XOR checksum byte when PROG_LOADER_CSUM_EN is defined.
module pico_prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [8:0]         load_len,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               len_err,
`ifdef PROG_LOADER_CSUM_EN
  output logic               csum_err,
`endif
  output logic               cpu_hold,
  output logic [2:0]         dbg_state
);

  // Byte handshake: a byte moves on a posedge where in_valid && in_ready;
  // in_ready is high only in the byte-collecting states and never depends on in_valid.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    WR   = 3'd4,
`ifdef PROG_LOADER_CSUM_EN
    CS   = 3'd6,
`endif
    FIN  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [8:0]           len_q, len_d;
  logic [8:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 hold_q, hold_d;
  logic                 len_err_q, len_err_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 csum_err_q, csum_err_d;
`endif
  logic                 xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b1;
      len_err_q  <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      len_err_q  <= len_err_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    len_err_d = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d     = csum_q;
    csum_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_len == 9'd0 || load_len > 9'(DEPTH)) begin
            len_err_d = 1'b1;
          end else begin
            len_d   = load_len;
            addr_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            hold_d  = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            csum_d  = '0;
`endif
            state_d = B0;
          end
        end
      end
      B0: if (xfer) begin
        wdata_d[INSTR_W-1 -: 8] = in_data;
`ifdef PROG_LOADER_CSUM_EN
        csum_d = csum_q ^ in_data;
`endif
        state_d = B1;
      end
      B1: if (xfer) begin
        wdata_d[15:8] = in_data;
`ifdef PROG_LOADER_CSUM_EN
        csum_d = csum_q ^ in_data;
`endif
        state_d = B2;
      end
      B2: if (xfer) begin
        wdata_d[7:0] = in_data;
`ifdef PROG_LOADER_CSUM_EN
        csum_d = csum_q ^ in_data;
`endif
        state_d = WR;
      end
      WR: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_d == len_q) begin
`ifdef PROG_LOADER_CSUM_EN
          state_d = CS;
`else
          state_d = FIN;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = B0;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CS: if (xfer) begin
        if (in_data == csum_q) begin
          state_d = FIN;
        end else begin
          // Bad image: keep the core held so it never runs a corrupt program.
          csum_err_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
`endif
      FIN: begin
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PROG_LOADER_CSUM_EN
  assign in_ready = (state_q == B0) || (state_q == B1) || (state_q == B2) || (state_q == CS);
  assign csum_err = csum_err_q;
`else
  assign in_ready = (state_q == B0) || (state_q == B1) || (state_q == B2);
`endif
  assign xfer       = in_valid && in_ready;
  assign imem_we    = (state_q == WR);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = (state_q == FIN);
  assign len_err    = len_err_q;
  assign cpu_hold   = hold_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pico_prog_loader.sv
// Directed bench for pico_prog_loader: drivers push expected imem writes and pulses into a queue,
// a negedge monitor pops and compares every output event.
module tb_pico_prog_loader;

  localparam int W = 36; // {kind[3:0], addr[7:0], data[23:0]}
  localparam logic [3:0] K_WR = 4'd1, K_DONE = 4'd2, K_LERR = 4'd3, K_CERR = 4'd4;

  logic        clk = 1'b0;
  logic        rst, load_start, in_valid;
  logic [8:0]  load_len;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, busy, done, len_err, cpu_hold;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic [2:0]  dbg_state;
`ifdef PROG_LOADER_CSUM_EN
  logic        csum_err;
`else
  logic        csum_err;
  assign csum_err = 1'b0;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] cs_acc;

  pico_prog_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .len_err(len_err),
`ifdef PROG_LOADER_CSUM_EN
    .csum_err(csum_err),
`endif
    .cpu_hold(cpu_hold), .dbg_state(dbg_state)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, state %0d", dbg_state);
    $fatal(1, "watchdog");
  end

  // ---- checking helpers ----
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [7:0] a, input logic [23:0] d);
    return {k, a, d};
  endfunction

  task automatic observe(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) check({"unexpected_", name}, act, '0);
    else check(name, act, exp_q.pop_front());
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (imem_we) begin
      observe("imem_write", ev(K_WR, imem_addr, imem_wdata));
      check1("in_ready_in_wr", in_ready, 1'b0);
    end
    if (done)     observe("done_pulse", ev(K_DONE, 8'h0, 24'h0));
    if (len_err)  observe("len_err_pulse", ev(K_LERR, 8'h0, 24'h0));
    if (csum_err) observe("csum_err_pulse", ev(K_CERR, 8'h0, 24'h0));
  end

  // ---- drivers (all called at a negedge, return at a negedge) ----
  task automatic start_load(input logic [8:0] len);
    load_start = 1'b1;
    load_len   = len;
    cs_acc     = 8'h00;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check1("byte_accept_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [7:0] addr, input logic [23:0] word, input int gap);
    logic [7:0] b;
    exp_q.push_back(ev(K_WR, addr, word));
    for (int i = 0; i < 3; i++) begin
      b = word[23-8*i -: 8];
      cs_acc ^= b;
      send_byte(b);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic finish_load();
    int t = 0;
    exp_q.push_back(ev(K_DONE, 8'h0, 24'h0));
`ifdef PROG_LOADER_CSUM_EN
    send_byte(cs_acc);
`endif
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check1("load_finished", busy, 1'b0);
    check1("hold_released", cpu_hold, 1'b0);
  endtask

  // ---- stimulus ----
  initial begin
    rst = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", {28'h0, imem_addr}, '0);
    check("rst_imem_wdata", {12'h0, imem_wdata}, '0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_len_err", len_err, 1'b0);
    check1("rst_cpu_hold", cpu_hold, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // len=1, back-to-back bytes; write one cycle after third byte, done the next
    start_load(9'd1);
    check1("t1_busy", busy, 1'b1);
    send_instr(8'h00, 24'h123456, 0);
    check1("t1_we_latency", imem_we, 1'b1);
    exp_q.push_back(ev(K_DONE, 8'h0, 24'h0));
`ifdef PROG_LOADER_CSUM_EN
    send_byte(cs_acc);
`else
    @(negedge clk);
`endif
    check1("t1_done", done, 1'b1);
    check1("t1_hold_during_fin", cpu_hold, 1'b1);
    @(negedge clk);
    check1("t1_hold_released", cpu_hold, 1'b0);
    check1("t1_busy_clear", busy, 1'b0);

    // len=3, in_valid toggling; new load re-asserts hold; load_start while busy ignored
    start_load(9'd3);
    check1("t2_hold_reassert", cpu_hold, 1'b1);
    load_start = 1'b1; load_len = 9'd0;
    @(negedge clk);
    load_start = 1'b0;
    send_instr(8'h00, 24'hA1B2C3, 1);
    send_instr(8'h01, 24'h0F1E2D, 1);
    send_instr(8'h02, 24'hFFEE01, 1);
    finish_load();

    // illegal lengths
    exp_q.push_back(ev(K_LERR, 8'h0, 24'h0));
    start_load(9'd0);
    check1("t3_len0_busy", busy, 1'b0);
    @(negedge clk);
    exp_q.push_back(ev(K_LERR, 8'h0, 24'h0));
    start_load(9'd257);
    check1("t3_len257_busy", busy, 1'b0);
    @(negedge clk);
    check1("t3_hold_unchanged", cpu_hold, 1'b0);

    // full depth: addresses must run 0..255 in order without wrapping
    start_load(9'd256);
    for (int i = 0; i < 256; i++)
      send_instr(8'(i), {8'(i), 8'(i) ^ 8'h5A, ~8'(i)}, 0);
    finish_load();

    // reset in the middle of a len=4 load
    start_load(9'd4);
    send_instr(8'h00, 24'h111111, 0);
    send_instr(8'h01, 24'h222222, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("t5_in_ready", in_ready, 1'b0);
    check1("t5_imem_we", imem_we, 1'b0);
    check("t5_imem_addr", {28'h0, imem_addr}, '0);
    check("t5_imem_wdata", {12'h0, imem_wdata}, '0);
    check1("t5_busy", busy, 1'b0);
    check1("t5_done", done, 1'b0);
    check1("t5_cpu_hold", cpu_hold, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    start_load(9'd1);
    send_instr(8'h00, 24'hDEAD01, 0);
    finish_load();

`ifdef PROG_LOADER_CSUM_EN
    // checksum good: 0x01^0x02^0x04 = 0x07
    start_load(9'd1);
    send_instr(8'h00, 24'h010204, 0);
    exp_q.push_back(ev(K_DONE, 8'h0, 24'h0));
    send_byte(8'h07);
    @(negedge clk);
    check1("t6_good_hold", cpu_hold, 1'b0);
    // checksum bad
    start_load(9'd1);
    send_instr(8'h00, 24'h010204, 0);
    exp_q.push_back(ev(K_CERR, 8'h0, 24'h0));
    send_byte(8'h06);
    check1("t6_bad_busy", busy, 1'b0);
    @(negedge clk);
    check1("t6_bad_hold", cpu_hold, 1'b1);
    check1("t6_bad_no_done", done, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_prog_loader.md
Name: pico_prog_loader

Overview:
- Input-side counterpart of the PICO_MIPS output monitor: writes the program the core fetches, rather than observing it.
- Accepts a byte stream over valid/ready, assembles MSB-first 24-bit instructions and writes them to instruction memory at incrementing 8-bit addresses from 0.
- Holds the core in reset (cpu_hold) until a complete load succeeds.
- Sits between the bench/host byte source and the PICO_MIPS instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width.
- INSTR_W, 24, instruction width; fixed at 3 bytes.
- DEPTH, 256, instruction memory depth; maximum load length.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse that begins a load; sampled in IDLE only.
- load_len  input  9  number of instructions, 1..DEPTH; sampled with load_start.
- in_valid  input  1  byte source has data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per instruction.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse on successful completion.
- len_err  output  1  one-cycle pulse when load_len is illegal.
- cpu_hold  output  1  keeps the core in reset while high.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, len_err=0, cpu_hold=1. FSM returns to IDLE and the byte and instruction counters clear.
- States: IDLE, B0, B1, B2, WR, FIN.
- IDLE:
  - load_start with load_len in 1..DEPTH: capture len, addr<=0, busy<=1, cpu_hold<=1, go to B0.
  - load_start with load_len=0 or >DEPTH: len_err=1 for one cycle, stay IDLE, cpu_hold unchanged.
- B0/B1/B2: in_ready=1. Each accepted byte fills wdata[23:16], [15:8], [7:0] respectively, then advances. No advance without a transfer; stalls of any length are allowed.
- WR:
  - in_ready=0; imem_we=1 for exactly this cycle with the current addr and assembled word.
  - Latency: the write strobe occurs the cycle after the third byte is accepted.
  - Next cycle: if written count == len, go to FIN; else addr+1 and go to B0.
- FIN: done=1 for one cycle, busy<=0, cpu_hold<=0, go to IDLE.
- Address wrap: with len=DEPTH the last write is at DEPTH-1. addr never wraps within a load.
- load_start while busy: ignored, with no error.
- in_valid outside B0..B2: not consumed; the source holds its byte.
- rst mid-load: abort immediately. Partially written memory is left as is; cpu_hold=1 until the next successful load.
- A new load after a completed one re-asserts cpu_hold at load_start.

Optional Feature:
- Macro: PROG_LOADER_CSUM_EN.
- Defined:
  - After the last WR, state CS accepts one extra byte with in_ready=1.
  - Expected value is the XOR of all instruction bytes of the load.
  - Match: go to FIN as normal.
  - Mismatch: csum_err output pulses 1 for one cycle, done is not pulsed, cpu_hold stays 1, busy<=0, return to IDLE.
  - csum_err resets to 0.
- Not defined: no CS state, no csum_err port, and FIN follows the last WR directly.

Test Plan:
- len=1, bytes 0x12,0x34,0x56 with in_valid held high -> imem_we at addr 0, wdata 0x123456, one cycle after third byte; done next cycle; cpu_hold 1->0.
- len=3, in_valid toggling every other cycle -> three writes at addr 0,1,2 with the correct words, no write without 3 accepted bytes, in_ready=0 in WR cycles.
- load_len=0 and then 257 -> len_err pulses each time, no imem_we, busy stays 0.
- len=256 -> last write at addr 0xFF, done once, imem_addr never wraps to 0 during the load.
- rst asserted after 2 instructions of a len=4 load -> all outputs at reset values next cycle, cpu_hold=1. A following len=1 load completes normally from addr 0.
- CSUM_EN, len=1, bytes 0x01,0x02,0x04:
  - Checksum 0x07 -> done.
  - Checksum 0x06 -> csum_err, no done, cpu_hold stays 1.
